// File: rtl/nios_processor_pio_pkg.sv
// Register map and helpers shared by the Nios II LED/switch PIO slaves.
// Used by both the input PIO and the output PIO.
package nios_processor_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    // All-ones brightness code for a given resolution (1..8 bits).
    function automatic logic [7:0] DUTY_FULL(input int unsigned pwm_w);
        return 8'((9'd1 << pwm_w) - 9'd1);
    endfunction

endpackage

// File: rtl/nios_processor_pwm_gen.sv
// Global brightness PWM: prescaler, step counter and a duty shadow
// that only reloads at period start so duty changes never glitch.
module nios_processor_pwm_gen
    import nios_processor_pio_pkg::*;
#(
    parameter int PWM_W    = 4,
    parameter int PRESCALE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty_reg,
    output logic             pwm_on
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PRE_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] DUTY_MAX = PWM_W'(DUTY_FULL(PWM_W));

    logic [PS_W-1:0]  pre_q, pre_d;
    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] act_q, act_d;
    logic             tick;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PS_W'(1);
        cnt_d = tick ? cnt_q + PWM_W'(1) : cnt_q;
        // Shadow reload on the same edge the step counter wraps to 0.
        act_d = (tick && (cnt_q == DUTY_MAX)) ? duty_reg : act_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
            act_q <= DUTY_MAX;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign pwm_on = (act_q == DUTY_MAX) || (cnt_q < act_q);

endmodule

// File: rtl/nios_processor_led_pio_out.sv
// Avalon-MM output PIO for the LED bank: DATA/DUTY registers,
// bit set/clear aliases and PWM-gated registered LED drive.
module nios_processor_led_pio_out
    import nios_processor_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               PWM_W       = 4,
    parameter int               PRESCALE    = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [PWM_W-1:0] DUTY_MAX = PWM_W'(DUTY_FULL(PWM_W));

    logic [WIDTH-1:0] data_q, data_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wr_en;
    logic             pwm_on;

    nios_processor_pwm_gen #(
        .PWM_W    (PWM_W),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk      (clk),
        .reset    (reset),
        .duty_reg (duty_q),
        .pwm_on   (pwm_on)
    );

    always_comb begin
        wr_en  = chipselect && !write_n;
        data_d = data_q;
        duty_d = duty_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = writedata[WIDTH-1:0];
                ADDR_DUTY:     duty_d = writedata[PWM_W-1:0];
                ADDR_OUTSET:   data_d = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d = data_q & ~writedata[WIDTH-1:0];
                default:       data_d = data_q;
            endcase
        end
        // Readback is free-running and side-effect free.
        case (address)
            ADDR_DATA: readdata_d = 32'(data_q);
            ADDR_DUTY: readdata_d = 32'(duty_q);
            default:   readdata_d = '0;
        endcase
        out_d = data_q & {WIDTH{pwm_on}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            duty_q     <= DUTY_MAX;
            readdata_q <= '0;
            out_q      <= '0;
        end else begin
            data_q     <= data_d;
            duty_q     <= duty_d;
            readdata_q <= readdata_d;
            out_q      <= out_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;

endmodule

// File: tb/tb_nios_processor_led_pio_out.sv
// Bench for the LED output PIO: directed scenarios plus random traffic
// against a period-arithmetic model of the register file and PWM.
module tb_nios_processor_led_pio_out;
    import nios_processor_pio_pkg::*;

    localparam int WIDTH    = 8;
    localparam int PWM_W    = 4;
    localparam int PRESCALE = 16;
    localparam int PERIOD   = PRESCALE * 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    int         k;
    logic [7:0] m_data;
    logic [3:0] m_duty;
    logic [3:0] m_act;

    nios_processor_led_pio_out #(
        .WIDTH       (WIDTH),
        .PWM_W       (PWM_W),
        .PRESCALE    (PRESCALE),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Brightness after kk clocks since reset: step index is elapsed
    // clocks divided by the prescale, modulo the number of steps.
    function automatic bit model_on(input int kk, input logic [3:0] act);
        int step_idx;
        step_idx = (kk / PRESCALE) % 16;
        return (act == 4'hF) || (step_idx < int'(act));
    endfunction

    task automatic model_reset();
        k      = 0;
        m_data = 8'h00;
        m_duty = 4'hF;
        m_act  = 4'hF;
    endtask

    // One bus cycle; returns what out_port/readdata must show after it.
    task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                        input logic [31:0] wd,
                        output logic [7:0] eo, output logic [31:0] er);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        eo = model_on(k, m_act) ? m_data : 8'h00;
        er = (a == 2'd0) ? {24'd0, m_data} :
             (a == 2'd1) ? {28'd0, m_duty} : 32'd0;
        k++;
        if (k % PERIOD == 0) m_act = m_duty;
        if (cs && !wn) begin
            case (a)
                2'd0: m_data = wd[7:0];
                2'd1: m_duty = wd[3:0];
                2'd2: m_data = m_data | wd[7:0];
                default: m_data = m_data & ~wd[7:0];
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] eo;
        logic [31:0] er;
        #1;
        checks++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got %h want 00", out_port);
        end
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd got %h want 0", readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 00000000", readdata);
        end
        step(1'b0, 1'b1, ADDR_DUTY, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'h0000_000F) begin
            errors++;
            $display("FAIL reset_rd_duty got %h want 0000000f", readdata);
        end
    endtask

    task automatic test_data_write();
        logic [7:0] eo;
        logic [31:0] er;
        step(1'b1, 1'b0, ADDR_DATA, 32'h0000_00A5, eo, er);
        step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        checks++;
        if (out_port !== 8'hA5) begin
            errors++;
            $display("FAIL data_out got %h want a5", out_port);
        end
        checks++;
        if (readdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL data_rd got %h want 000000a5", readdata);
        end
    endtask

    task automatic test_set_clear();
        logic [7:0] eo;
        logic [31:0] er;
        step(1'b1, 1'b0, ADDR_DATA, 32'h0000_00F0, eo, er);
        step(1'b1, 1'b0, ADDR_OUTSET, 32'h0000_000F, eo, er);
        step(1'b1, 1'b0, ADDR_OUTCLEAR, 32'h0000_0081, eo, er);
        checks++;
        if (out_port !== 8'hFF) begin
            errors++;
            $display("FAIL outset got %h want ff", out_port);
        end
        step(1'b0, 1'b1, ADDR_OUTSET, 32'd0, eo, er);
        checks++;
        if (out_port !== 8'h7E) begin
            errors++;
            $display("FAIL outclear got %h want 7e", out_port);
        end
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL rd_addr2 got %h want 0", readdata);
        end
        step(1'b0, 1'b1, ADDR_OUTCLEAR, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL rd_addr3 got %h want 0", readdata);
        end
    endtask

    task automatic test_pwm_duty4();
        logic [7:0] eo;
        logic [31:0] er;
        int on_cnt, first_on, last_on;
        step(1'b1, 1'b0, ADDR_DATA, 32'h0000_00FF, eo, er);
        step(1'b1, 1'b0, ADDR_DUTY, 32'h0000_0004, eo, er);
        while (k % PERIOD != 0) step(1'b0, 1'b1, ADDR_DUTY, 32'd0, eo, er);
        on_cnt   = 0;
        first_on = -1;
        last_on  = -1;
        for (int j = 0; j < PERIOD; j++) begin
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 32'd0, eo, er);
            checks++;
            if (out_port !== eo) begin
                errors++;
                $display("FAIL pwm4_model j=%0d got %h want %h", j, out_port, eo);
            end
            if (out_port == 8'hFF) begin
                on_cnt++;
                if (first_on < 0) first_on = j;
                last_on = j;
            end
        end
        checks++;
        if (on_cnt != 64) begin
            errors++;
            $display("FAIL pwm4_on_count got %0d want 64", on_cnt);
        end
        checks++;
        if (first_on != 0 || last_on != 63) begin
            errors++;
            $display("FAIL pwm4_window got %0d..%0d want 0..63", first_on, last_on);
        end
    endtask

    task automatic test_duty0_midperiod();
        logic [7:0] eo;
        logic [31:0] er;
        int bad;
        step(1'b1, 1'b0, ADDR_DUTY, 32'h0000_000F, eo, er);
        while (k % PERIOD != 0) step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        while (k % PERIOD != 100) step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        step(1'b1, 1'b0, ADDR_DUTY, 32'd0, eo, er);
        step(1'b0, 1'b1, ADDR_DUTY, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL duty0_rd got %h want 0", readdata);
        end
        bad = 0;
        while (k % PERIOD != 0) begin
            step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
            if (out_port !== 8'hFF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL duty0_before_wrap got %0d off cycles want 0", bad);
        end
        bad = 0;
        for (int j = 0; j < 300; j++) begin
            step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
            if (out_port !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL duty0_after_wrap got %0d on cycles want 0", bad);
        end
    endtask

    task automatic test_ignored_writes();
        logic [7:0] eo;
        logic [31:0] er;
        step(1'b0, 1'b0, ADDR_DATA, 32'h0000_0055, eo, er);
        step(1'b1, 1'b1, ADDR_DATA, 32'h0000_0055, eo, er);
        step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL no_write got %h want 000000ff", readdata);
        end
        step(1'b1, 1'b0, ADDR_DATA, 32'hFFFF_FF3C, eo, er);
        step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'h0000_003C) begin
            errors++;
            $display("FAIL upper_bits got %h want 0000003c", readdata);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] eo;
        logic [31:0] er;
        step(1'b1, 1'b0, ADDR_DUTY, 32'h0000_000F, eo, er);
        step(1'b1, 1'b0, ADDR_DATA, 32'h0000_005A, eo, er);
        repeat (40) step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        reset = 1'b1;
        #1;
        checks++;
        if (out_port !== 8'h00 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset got %h/%h want 00/0", out_port, readdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b1, ADDR_DATA, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'd0 || out_port !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_data got %h/%h want 0/00", readdata, out_port);
        end
        step(1'b0, 1'b1, ADDR_DUTY, 32'd0, eo, er);
        checks++;
        if (readdata !== 32'h0000_000F) begin
            errors++;
            $display("FAIL post_reset_duty got %h want 0000000f", readdata);
        end
    endtask

    task automatic test_random();
        logic [7:0] eo;
        logic [31:0] er;
        logic cs, wn;
        for (int i = 0; i < 3000; i++) begin
            cs = ($urandom_range(0, 9) < 7);
            wn = ($urandom_range(0, 9) < 6);
            step(cs, wn, 2'($urandom_range(0, 3)), $urandom, eo, er);
            checks++;
            if (out_port !== eo) begin
                errors++;
                $display("FAIL rand_out i=%0d got %h want %h", i, out_port, eo);
            end
            checks++;
            if (readdata !== er) begin
                errors++;
                $display("FAIL rand_rd i=%0d got %h want %h", i, readdata, er);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_data_write();
        test_set_clear();
        test_pwm_duty4();
        test_duty0_midperiod();
        test_ignored_writes();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
